shift_add_mul_seq: RTL and testbench

Sequential shift-add multiplier stage of the datapath. It accepts a WIDTH-bit multiplicand and multiplier from the operand shift registers through a valid/ready handshake. It computes their unsigned 2*WIDTH-bit product one multiplier bit per clock and holds the result under a valid/ready output handshake until the downstream result stage consumes it.

---
 rtl/shift_add_mul_seq.sv | 127 ++++++++++++
 tb/tb_shift_add_mul_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mul_seq.sv
// -----------------------------------------------------------------------------
// shift_add_mul_seq
//
// Sequential unsigned shift-add multiplier. Operands are taken through a
// valid/ready handshake. One multiplier bit is consumed per clock. The
// 2*WIDTH-bit product is then held under a valid/ready output handshake until
// the downstream stage takes it.
//
// Parameters:
//   WIDTH      operand width (product is 2*WIDTH bits), default 4
//
// Ports:
//   Clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   operands present on mcand/mplier
//   in_ready   block can accept operands (IDLE and not in reset)
//   mcand      multiplicand, unsigned
//   mplier     multiplier, unsigned
//   out_valid  product is valid (DONE)
//   out_ready  downstream accepts the product
//   product    registered product (accumulator)
//   busy       high while the multiply is running
//
// Optional feature:
//   MUL_EARLY_TERM_EN  when defined, RUN also ends once no set multiplier
//                      bits remain, so latency depends on the highest set bit
//                      of mplier. Product values do not change.
// -----------------------------------------------------------------------------
module shift_add_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  // A one-bit operand still needs a one-bit counter.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] m_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_step;
  logic               early_done;

  assign in_ready  = (state == IDLE) && reset;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign product   = p_reg;
  assign accept    = in_valid && in_ready;

`ifdef MUL_EARLY_TERM_EN
  // After this step no set multiplier bits remain, so the sum is final.
  assign early_done = ((q_reg >> 1) == '0);
`else
  assign early_done = 1'b0;
`endif

  assign last_step = (cnt == LAST_CNT) || early_done;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so that no path leaves it
  // unassigned; otherwise a latch would be inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept)    state_next = RUN;
      RUN:  if (last_step) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Datapath. P is left untouched in DONE and back in IDLE so the product
  // stays visible until the next acceptance clears it.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      m_reg <= '0;
      q_reg <= '0;
      p_reg <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        m_reg <= {{WIDTH{1'b0}}, mcand};
        q_reg <= mplier;
        p_reg <= '0;
        cnt   <= '0;
      end
    end else if (state == RUN) begin
      // Unsigned operands cannot overflow 2*WIDTH bits.
      p_reg <= p_reg + (q_reg[0] ? m_reg : '0);
      m_reg <= m_reg << 1;
      q_reg <= q_reg >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_add_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mul_seq
//
// Self-checking bench for shift_add_mul_seq at WIDTH=4. Directed cases cover
// the basic multiply, extremes, zero/one operands, backpressure, rejection,
// reset abort and back-to-back throughput. A randomized loop follows. Expected
// products and latencies come from plain arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_shift_add_mul_seq;

  localparam int W = 4;

  logic           Clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int n_checks;
  int n_fails;
  int cyc;

  shift_add_mul_seq #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand     (mcand),
    .mplier    (mplier),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected latency in cycles from acceptance to out_valid.
  function automatic int ref_lat(input int b);
    int h;
    h = W;
`ifdef MUL_EARLY_TERM_EN
    h = 0;
    for (int i = 0; i < W; i++) if ((b >> i) & 1) h = i + 1;
    if (h < 1) h = 1;
`endif
    return h;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  // One full transaction: accept, measure latency, hold under backpressure,
  // optionally pulse in_valid while busy/done, then consume.
  task automatic do_mul(input int a, input int b, input int hold, input bit reject);
    int lat;
    int exp_p;
    exp_p = a * b;
    wait_ready();
    mcand    = W'(a);
    mplier   = W'(b);
    in_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("in_ready_in_run", in_ready, 0);
    if (reject) begin
      mcand    = W'(~a);
      mplier   = W'(~b);
      in_valid = 1'b1;
    end
    lat = 0;
    while (lat < 20) begin
      @(posedge Clk);
      in_valid = 1'b0;
      lat++;
      @(negedge Clk);
      if (out_valid) break;
    end
    check("latency", lat, ref_lat(b));
    check("product", product, exp_p);
    check("busy_in_done", busy, 0);
    for (int i = 0; i < hold; i++) begin
      if (reject && i == 0) in_valid = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      in_valid = 1'b0;
      check("hold_out_valid", out_valid, 1);
      check("hold_product", product, exp_p);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    out_ready = 1'b0;
    check("consumed_out_valid", out_valid, 0);
    check("consumed_in_ready", in_ready, 1);
    check("consumed_product_kept", product, exp_p);
  endtask

  initial begin
    int t0;
    int t1;
    int n;
    n_checks  = 0;
    n_fails   = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mcand     = '0;
    mplier    = '0;

    // Reset state.
    #12;
    check("rst_product", product, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge Clk);
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Directed cases.
    do_mul(13, 11, 0, 1'b0);
    do_mul(15, 15, 5, 1'b1);
    do_mul(0, 9, 0, 1'b0);
    do_mul(7, 0, 0, 1'b0);
    do_mul(9, 1, 0, 1'b0);

    // Reset abort two steps into 6 x 5.
    wait_ready();
    mcand = W'(6); mplier = W'(5); in_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    in_valid = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_product", product, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    repeat (2) @(negedge Clk);
    reset = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge Clk);
      if (out_valid) n++;
    end
    check("abort_no_out_valid", n, 0);
    do_mul(6, 5, 0, 1'b0);

    // Back-to-back with out_ready held high.
    out_ready = 1'b1;
    mcand = W'(3); mplier = W'(4); in_valid = 1'b1;
    wait_ready();
    t0 = cyc;
    @(posedge Clk);
    @(negedge Clk);
    mcand = W'(10); mplier = W'(10);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("b2b_first_product", product, 12);
    wait_ready();
    t1 = cyc;
    check("b2b_interval", t1 - t0, ref_lat(4) + 2);
    @(posedge Clk);
    @(negedge Clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("b2b_second_product", product, 100);
    @(negedge Clk);
    out_ready = 1'b0;
    check("b2b_idle", in_ready, 1);

    // Randomized operands and backpressure.
    for (int k = 0; k < 12; k++) begin
      do_mul(int'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
